mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares one `WIDTH`-bit 4:1 multiplexer path between four requesters and drives a single valid/ready output channel. It owns the mux select lines (`sel[1]`=s1, `sel[0]`=s0) and registers a one-hot grant, so exactly one requester's data reaches `out_data` at a time. It is used wherever the processor datapath funnels four sources (e.g. writeback/result sources) onto one shared bus.

## Interface
- `WIDTH`, 32, data width of each requester and of `out_data`
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high
- `req`  input  4  request per requester; must stay high until `ack` for that requester
- `lock`  input  4  requester i keeps grant after its transfer while `lock[i]` and `req[i]`
- `data0`..`data3`  input  WIDTH each  requester payloads
- `out_ready`  input  1  consumer accepts `out_data` this cycle
- `out_valid`  output  1  `out_data` holds a valid beat
- `out_data`  output  WIDTH  selected payload
- `ack`  output  4  one-hot, transfer completed for requester i this cycle
- `grant`  output  4  registered one-hot grant (all zero when idle)
- `sel`  output  2  mux select = index of granted requester
- `busy`  output  1  `grant != 0`

## Operation
- Two states: IDLE (`grant`=0) and OWNED (`grant` one-hot).
- Priority pointer `ptr` (2 bits) names the highest-priority requester; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE: if any `req`, next edge grants the first requester in search order; `ptr` unchanged.
- OWNED, combinational outputs: `sel` = encoded `grant`; `out_data` = `data[sel]` through the mux; `out_valid` = `req[sel]`; `ack[sel]` = `out_valid & out_ready`, other `ack` bits 0.
- OWNED, on handshake (`out_valid & out_ready`) for index g:
  - `lock[g]` high and `req[g]` high: grant held, `ptr` unchanged.
  - else `ptr` <= g+1 mod 4; next grant = first requester in new search order with `req` high (g itself is searched last, so a lone requester is re-granted); none -> IDLE.
- OWNED, `req[g]` dropped without handshake (protocol violation): next edge re-arbitrates with `ptr` unchanged, no `ack` issued.
- `sel` is 0 while idle; `out_data` then shows `data0` but `out_valid`=0.

## Timing
- Reset (async assert, sync release by source): `grant`=0, `ptr`=0, `sel`=0, `out_valid`=0, `ack`=0, `busy`=0.
- Request-to-grant latency from IDLE: 1 cycle (req sampled edge N, `grant`/`out_valid` high after edge N).
- Grant-to-grant handover after handshake: 0 bubble cycles; next owner's `out_valid` valid the cycle after the handshake.
- Handshake completes in the cycle `out_valid & out_ready`; `ack` is combinational that same cycle.
- Simultaneous requests: resolved strictly by `ptr`; never two bits in `grant`.
- `out_ready` held low: grant, `sel`, `out_data` stable indefinitely; no timeout.
- Reset mid-transfer: outputs clear immediately, pending beat is dropped, no `ack`.
- `ptr` wraps 3 -> 0.

## Structure
- Shared include/package: state encodings (IDLE, OWNED), `N_REQ`=4, and the one-hot-to-index encoding function.
- One sub-module: `mux4to1_32bit` (WIDTH-parameterised 4:1 data mux, selects `s1,s0`); arbiter FSM, pointer and grant logic in the top.

## Test plan
- Reset then `req`=0001, `data0`=0xAAAA5555, `out_ready`=1 -> `grant`=0001 after 1 edge, `out_data`=0xAAAA5555, `ack`=0001 one cycle, then IDLE with `ptr`=1.
- `req`=1111 held, `out_ready`=1 from reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, `sel` 0,1,2,3,0, no idle cycles between.
- `req`=0110, `out_ready`=0 for 5 cycles then 1 -> `grant`=0010 and `out_data`=`data1` stable 5 cycles, `ack`=0010 on release, next grant 0100.
- `req`=1001, `lock`=1000, `ptr` pointing at 3 -> requester 3 gets 3 consecutive beats while locked; on `lock[3]`=0 after handshake grant moves to 0001.
- `req[2]` dropped while granted with `out_ready`=0 -> no `ack`, next edge grant moves to next requester (or IDLE), `ptr` unchanged.
- Assert `reset` mid-cycle while `grant`=0100 and `out_valid`=1 -> `grant`, `out_valid`, `ack`, `sel` go to 0 before next clock edge; first grant after release follows `ptr`=0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// requester count and the grant encode / round-robin search helpers.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // First requester at or after ptr (mod 4), as a one-hot; zero when none.
  // Scanning from the far end lets the closest hit overwrite the others.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [1:0]       ptr);
    logic [N_REQ-1:0] pick;
    logic [1:0]       idx;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// WIDTH-bit 4:1 data multiplexer; {s1,s0} selects d0..d3.
module mux4to1_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // NOTE: a full case with a default keeps this purely combinational (no latch).
  always_comb begin
    unique case ({s1, s0})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux path between four valid/ready
// requesters; registered one-hot grant, combinational ack on handshake.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       ack,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             busy
);

  state_t     state;
  logic [1:0] ptr;
  logic       handshake;
  logic [3:0] next_after;
  logic [3:0] repick;

  assign sel       = (state == OWNED) ? onehot_to_idx(grant) : 2'd0;
  assign out_valid = (state == OWNED) && req[sel];
  assign handshake = out_valid && out_ready;
  assign busy      = |grant;

  // Owner searched last after its own beat, so a lone requester is re-granted.
  assign next_after = rr_pick(req, sel + 2'd1);
  assign repick     = rr_pick(req, ptr);

  always_comb begin
    ack = '0;
    if (handshake) ack[sel] = 1'b1;
  end

  mux4to1_32bit #(.WIDTH(WIDTH)) u_mux (
    .s1 (sel[1]),
    .s0 (sel[0]),
    .d0 (data0),
    .d1 (data1),
    .d2 (data2),
    .d3 (data3),
    .y  (out_data)
  );

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant <= repick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (handshake) begin
            if (!(lock[sel] && req[sel])) begin
              ptr   <= sel + 2'd1;
              grant <= next_after;
              state <= (|next_after) ? OWNED : IDLE;
            end
          end else if (!req[sel]) begin
            // Owner abandoned its request: re-arbitrate without moving ptr.
            grant <= repick;
            state <= (|repick) ? OWNED : IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter with hand-written
// sequences for the reset-mid-transfer corner.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req, lock;
  logic [WIDTH-1:0] data0, data1, data2, data3;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       ack, grant;
  logic [1:0]       sel;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] data_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return data0;
      2'd1:    return data1;
      2'd2:    return data2;
      default: return data3;
    endcase
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] s,
                               input logic v, input logic [3:0] a);
    check({tag, ".grant"},    32'(grant),     32'(g));
    check({tag, ".sel"},      32'(sel),       32'(s));
    check({tag, ".valid"},    32'(out_valid), 32'(v));
    check({tag, ".ack"},      32'(ack),       32'(a));
    check({tag, ".busy"},     32'(busy),      32'(g != 4'b0000));
    check({tag, ".out_data"}, out_data,       data_of(s));
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                              input logic [3:0] g, input logic [1:0] s, input logic v,
                              input logic [3:0] a);
    vec_t t;
    t.req = r; t.lock = l; t.rdy = rdy; t.grant = g; t.sel = s; t.valid = v; t.ack = a;
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single requester: grant, ack, re-grant while req still high, then idle (ptr=1).
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0000));
    // All four requesting from ptr=1: back-to-back rotation with wrap 3 -> 0.
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001));
    // Back-pressure: grant 0010 stable five cycles, then handover to 0100.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000));
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010));
    // Owner drops req without handshake: no ack, idle, ptr stays 2.
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100));
    // Lock: requester 3 keeps three beats, released lock hands over to 0.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b1001, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000));
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000));

    data0 = 32'hAAAA_5555;
    data1 = 32'h1111_1111;
    data2 = 32'h2222_2222;
    data3 = 32'h3333_3333;
    req = '0; lock = '0; out_ready = 1'b0;
    reset = 1'b1;

    #1;
    check_outputs("reset_async", 4'b0000, 2'd0, 1'b0, 4'b0000);
    next_cycle();
    req = 4'b1111;
    #1;
    check_outputs("reset_held", 4'b0000, 2'd0, 1'b0, 4'b0000);
    req = '0;
    next_cycle();
    reset = 1'b0;

    foreach (vecs[i]) begin
      req       = vecs[i].req;
      lock      = vecs[i].lock;
      out_ready = vecs[i].rdy;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel,
                    vecs[i].valid, vecs[i].ack);
      next_cycle();
    end

    // Reset mid-transfer while requester 2 owns with a pending beat (ptr=1).
    req = 4'b0101; lock = '0; out_ready = 1'b1;
    #1;
    check_outputs("pre_rst_hs", 4'b0001, 2'd0, 1'b1, 4'b0001);
    next_cycle();
    req = 4'b0100; out_ready = 1'b0;
    #1;
    check_outputs("pre_rst_own", 4'b0100, 2'd2, 1'b1, 4'b0000);
    #1;
    reset = 1'b1;
    #1;
    check_outputs("mid_rst", 4'b0000, 2'd0, 1'b0, 4'b0000);
    next_cycle();
    reset = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    #1;
    check_outputs("post_rst_idle", 4'b0000, 2'd0, 1'b0, 4'b0000);
    next_cycle();
    #1;
    check_outputs("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
